mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage between EX/MEM and MEM/WB registers. Performs byte/half/word
//  loads and stores to a wait-stated data memory via req/ack handshake, stalls the
//  pipeline until the access completes, formats load data (lane select + sign/zero
//  extend) and presents it as MemData to the MEM/WB register. Flags misaligned
//  accesses and memory timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles waiting for dmem_ack before abort (1..255)
// PORTS
//  Clk            in   1   clock, all state on posedge
//  Rst            in   1   synchronous, active-high reset
//  MemRead_in     in   1   load request from EX/MEM
//  MemWrite_in    in   1   store request from EX/MEM (never both with MemRead_in)
//  MemSize_in     in   2   00 byte, 01 half, 10 word; 11 treated as word
//  MemSigned_in   in   1   1 = sign-extend load, 0 = zero-extend
//  Addr_in        in   32  byte address (ALU result)
//  WriteData_in   in   32  store data, value in low bits
//  dmem_req       out  1   access request, held until ack or abort
//  dmem_we        out  1   1 = write, valid with dmem_req
//  dmem_addr      out  32  word address {Addr_in[31:2],2'b00}
//  dmem_be        out  4   byte enables, bit i = byte lane i (little-endian)
//  dmem_wdata     out  32  store data replicated to all lanes of its size
//  dmem_rdata     in   32  read word, valid when dmem_ack=1
//  dmem_ack       in   1   one-cycle completion pulse
//  MemData_out    out  32  formatted load data to MEM/WB
//  Stall_out      out  1   freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB must not load
//  Misaligned_out out  1   one-cycle pulse: misaligned access dropped
//  BusErr_out     out  1   one-cycle pulse: access aborted on timeout
// BEHAVIOUR
//  Reset: state IDLE, dmem_req/we=0, dmem_be=0, MemData_out=0, Misaligned_out=0,
//   BusErr_out=0, wait counter=0. Rst mid-access drops dmem_req next edge; late ack ignored.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: acc = MemRead_in|MemWrite_in. If acc and aligned: dmem_req=1 combinationally
//   same cycle, Stall_out=1, -> WAIT. If acc and misaligned (half: Addr[0]!=0; word:
//   Addr[1:0]!=0): no request, Misaligned_out=1 next cycle, MemData_out<=0, no stall,
//   stay IDLE. No acc: outputs idle, MemData_out holds.
//  WAIT: dmem_req/we/addr/be/wdata held stable from EX/MEM (frozen by Stall_out);
//   Stall_out=1; counter++. dmem_ack=1: MemData_out<=formatted rdata (loads only; stores
//   leave it unchanged), -> RESP. Counter==TIMEOUT_CYCLES without ack: drop req,
//   MemData_out<=0, BusErr_out pulses, -> RESP. Ack on same cycle as timeout: ack wins.
//  RESP: Stall_out=0, dmem_req=0 for exactly one cycle; pipeline advances, MEM/WB
//   captures MemData_out. -> IDLE unconditionally (next instruction evaluated in IDLE).
//  Min latency: ack in first WAIT cycle -> 2 stall cycles per access.
//  Load format: lane=Addr[1:0]; byte=rdata[8*lane+:8]; half=rdata[16*Addr[1]+:16];
//   extend to 32 per MemSigned_in. Word passes through.
//  Store: byte be=1<<lane, wdata={4{WD[7:0]}}; half be=Addr[1]?1100:0011,
//   wdata={2{WD[15:0]}}; word be=1111, wdata=WD.
//  Counter 8 bits, cleared on entry to WAIT; never wraps (abort at TIMEOUT_CYCLES).
// STRUCTURE
//  Shared include mem_defs.vh: MEM_SZ_BYTE/HALF/WORD encodings, state codes
//   ST_IDLE/ST_WAIT/ST_RESP. Sub-module load_formatter (combinational:
//   rdata, lane, size, signed -> 32-bit result), reusable for a future cache.
// TESTING
//  lw 0x100, rdata=0xDEADBEEF, ack after 3 cycles -> Stall 4 cycles, MemData=0xDEADBEEF in RESP.
//  lb signed 0x103, rdata=0x80FF0102 -> MemData=0xFFFFFF80; lbu same -> 0x00000080.
//  sh 0x202 data 0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1, addr=0x200.
//  lw 0x101 -> no dmem_req, Misaligned_out pulse, Stall_out never 1.
//  TIMEOUT_CYCLES=4, no ack -> req drops after 4 WAIT cycles, BusErr pulse, MemData=0.
//  Rst asserted during WAIT, ack following cycle -> req=0, state IDLE, MemData stays 0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_pkg
// Brief    : Shared encodings and lane helpers for the MEM pipeline stage:
//            access sizes, FSM states, alignment and byte-lane functions.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    // Access size encodings carried on MemSize_in (2'b11 behaves as a word)
    localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] MEM_SZ_HALF = 2'b01;
    localparam logic [1:0] MEM_SZ_WORD = 2'b10;

    // Width of the dmem_ack wait counter
    localparam int CNT_W = 8;

    // MEM stage sequencing
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Halves need an even address, words a 4-byte aligned one; bytes never trap
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            MEM_SZ_BYTE: mis = 1'b0;
            MEM_SZ_HALF: mis = lane[0];
            default:     mis = |lane;
        endcase
        return mis;
    endfunction

    // Little-endian byte enables for the addressed lane(s)
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            MEM_SZ_BYTE: be = 4'b0001 << lane;
            MEM_SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data so the enabled lanes carry it regardless of offset
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            MEM_SZ_BYTE: r = {4{wd[7:0]}};
            MEM_SZ_HALF: r = {2{wd[15:0]}};
            default:     r = wd;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Brief    : Data-memory req/ack bus between the MEM stage (master) and the
//            wait-stated data memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage_load_formatter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_load_formatter
// Brief    : Combinational load formatter: selects the byte/half lane from a
//            read word and sign- or zero-extends it to 32 bits. Kept separate
//            so a future cache refill path can reuse it.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage_load_formatter
    import mem_access_stage_pkg::*;
(
    input  wire logic [31:0] rdata_i,
    input  wire logic [1:0]  lane_i,
    input  wire logic [1:0]  size_i,
    input  wire logic        signed_i,
    output logic      [31:0] result_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extraction followed by extension; word and 2'b11 pass through
    always_comb begin
        w_byte   = 8'(rdata_i >> {lane_i, 3'b000});
        w_half   = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        result_o = rdata_i;
        case (size_i)
            MEM_SZ_BYTE: result_o = {{24{signed_i & w_byte[7]}}, w_byte};
            MEM_SZ_HALF: result_o = {{16{signed_i & w_half[15]}}, w_half};
            default:     result_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : MEM pipeline stage. Issues byte/half/word loads and stores to a
//            wait-stated data memory over req/ack, stalls the pipeline until
//            the access completes, formats load data into MemData_out and
//            flags misaligned accesses and ack timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic          Clk,
    input  wire logic          Rst,
    input  wire logic          MemRead_in,
    input  wire logic          MemWrite_in,
    input  wire logic [1:0]    MemSize_in,
    input  wire logic          MemSigned_in,
    input  wire logic [31:0]   Addr_in,
    input  wire logic [31:0]   WriteData_in,
    mem_access_stage_if.master dmem,
    output logic      [31:0]   MemData_out,
    output logic               Stall_out,
    output logic               Misaligned_out,
    output logic               BusErr_out
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      memdata_q;
    logic             misaligned_q;
    logic             buserr_q;

    logic             w_acc;
    logic             w_mis;
    logic             w_start;
    logic             w_active;
    logic             w_timeout;
    logic [31:0]      w_load_data;

    // Request decode: a new aligned access raises req in the same IDLE cycle
    always_comb begin
        w_acc     = MemRead_in | MemWrite_in;
        w_mis     = is_misaligned(MemSize_in, Addr_in[1:0]);
        w_start   = (state_q == ST_IDLE) && w_acc && !w_mis;
        w_active  = !Rst && (w_start || (state_q == ST_WAIT));
        cnt_d     = cnt_q + 1'b1;
        w_timeout = (cnt_d == TIMEOUT_LIMIT);
    end

    // Bus outputs follow the EX/MEM inputs, which Stall_out keeps frozen
    always_comb begin
        dmem.dmem_req   = w_active;
        dmem.dmem_we    = w_active & MemWrite_in;
        dmem.dmem_addr  = {Addr_in[31:2], 2'b00};
        dmem.dmem_be    = w_active ? byte_enables(MemSize_in, Addr_in[1:0]) : 4'b0000;
        dmem.dmem_wdata = store_lanes(MemSize_in, WriteData_in);
        Stall_out       = w_active;
    end

    mem_access_stage_load_formatter u_load_formatter (
        .rdata_i  (dmem.dmem_rdata),
        .lane_i   (Addr_in[1:0]),
        .size_i   (MemSize_in),
        .signed_i (MemSigned_in),
        .result_o (w_load_data)
    );

    // Access sequencer with registered result and one-cycle error pulses
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            memdata_q    <= '0;
            misaligned_q <= 1'b0;
            buserr_q     <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            buserr_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_acc) begin
                        if (w_mis) begin
                            misaligned_q <= 1'b1;
                            memdata_q    <= '0;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    // An ack arriving on the timeout cycle still completes normally
                    if (dmem.dmem_ack) begin
                        if (MemRead_in) begin
                            memdata_q <= w_load_data;
                        end
                        state_q <= ST_RESP;
                    end else if (w_timeout) begin
                        memdata_q <= '0;
                        buserr_q  <= 1'b1;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign MemData_out    = memdata_q;
    assign Misaligned_out = misaligned_q;
    assign BusErr_out     = buserr_q;

endmodule
`default_nettype wire
